// File: rtl/ter_poly_mac_if.sv
// Handshake/data bundle for ter_poly_mac; the master drives the operands and the beat stream.
interface ter_poly_mac_if #(
  parameter int N = 701
);
  logic           start;
  logic [2*N-1:0] b_in;
  logic           m_valid;
  logic [1:0]     m_coef;
  logic           m_ready;
  logic           busy;
  logic           done;
  logic [2*N-1:0] c_out;

  modport master (
    output start, b_in, m_valid, m_coef,
    input  m_ready, busy, done, c_out
  );

  modport slave (
    input  start, b_in, m_valid, m_coef,
    output m_ready, busy, done, c_out
  );
endinterface

// File: rtl/ter_poly_mac.sv
// Serial ternary polynomial multiplier: c = m * b mod (3, x^N - 1), m streamed one coefficient per beat.
// Optional macro TER_PHI_N_REDUCE_EN adds a REDUCE cycle giving the canonical result mod (3, Phi_N).
module ter_poly_mac #(
  parameter int N  = 701,
  parameter int CW = 10
) (
  input logic           clk,
  input logic           rst,
  ter_poly_mac_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
`ifdef TER_PHI_N_REDUCE_EN
    S_REDUCE,
`endif
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [2*N-1:0] r_q, r_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           m_ready_q, m_ready_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           beat;

  // Coefficient codes: 01 = +1, 11 = -1, 00 and 10 both read as 0.
  function automatic logic [1:0] t_val(input logic [1:0] a);
    case (a)
      2'b01:   t_val = 2'd1;
      2'b11:   t_val = 2'd2;
      default: t_val = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] t_neg(input logic [1:0] a);
    case (a)
      2'b01:   t_neg = 2'b11;
      2'b11:   t_neg = 2'b01;
      default: t_neg = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] t_mul(input logic [1:0] a, input logic [1:0] b);
    if (t_val(a) != 2'd0 && t_val(b) != 2'd0) t_mul = (a[1] ^ b[1]) ? 2'b11 : 2'b01;
    else                                      t_mul = 2'b00;
  endfunction

  function automatic logic [1:0] t_add(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, t_val(a)} + {1'b0, t_val(b)};
    if (s >= 3'd3) s = s - 3'd3;
    case (s)
      3'd1:    t_add = 2'b01;
      3'd2:    t_add = 2'b11;
      default: t_add = 2'b00;
    endcase
  endfunction

  assign beat = bus.m_valid & m_ready_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    r_d     = r_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          r_d     = bus.b_in;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (beat) begin
          for (int i = 0; i < N; i++)
            acc_d[2*i +: 2] = t_add(acc_q[2*i +: 2], t_mul(bus.m_coef, r_q[2*i +: 2]));
          // Multiply r by x: coefficients move up one slot, the top one wraps to slot 0.
          r_d   = {r_q[2*N-3:0], r_q[2*N-1 -: 2]};
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(N-1)) begin
`ifdef TER_PHI_N_REDUCE_EN
            state_d = S_REDUCE;
`else
            state_d = S_DONE;
`endif
          end
        end
      end
`ifdef TER_PHI_N_REDUCE_EN
      S_REDUCE: begin
        // Subtracting c_{N-1} * Phi_N zeroes the top coefficient.
        for (int i = 0; i < N; i++)
          acc_d[2*i +: 2] = t_add(acc_q[2*i +: 2], t_neg(acc_q[2*N-1 -: 2]));
        state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are decoded from the next state so they are registered yet cycle-exact.
    m_ready_d = (state_d == S_RUN);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      r_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      m_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      r_q       <= r_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      m_ready_q <= m_ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.m_ready = m_ready_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.c_out   = acc_q;
endmodule

// File: tb/tb_ter_poly_mac.sv
// Directed bench for ter_poly_mac: an N=5 instance for hand-computed vectors and an N=701 instance
// for reset abort and a full-size product against a convolution model.
module tb_ter_poly_mac;
  localparam int W = 1408;  // 22 x 64-bit chunks, wide enough for 2*701 bits
`ifdef TER_PHI_N_REDUCE_EN
  localparam int RED = 1;
`else
  localparam int RED = 0;
`endif

  logic clk = 1'b0;
  logic rst5 = 1'b1;
  logic rst701 = 1'b1;
  always #5 clk = ~clk;

  ter_poly_mac_if #(.N(5))   i5 ();
  ter_poly_mac_if #(.N(701)) i701 ();

  ter_poly_mac #(.N(5),   .CW(3))  u5   (.clk(clk), .rst(rst5),   .bus(i5));
  ter_poly_mac #(.N(701), .CW(10)) u701 (.clk(clk), .rst(rst701), .bus(i701));

  int n_cmp = 0;
  int n_bad = 0;
  int sel   = 0;

  logic         obs_m_ready, obs_busy, obs_done;
  logic [W-1:0] obs_c;

  always_comb begin
    obs_c = '0;
    if (sel != 0) begin
      obs_m_ready     = i701.m_ready;
      obs_busy        = i701.busy;
      obs_done        = i701.done;
      obs_c[1401:0]   = i701.c_out;
    end else begin
      obs_m_ready     = i5.m_ready;
      obs_busy        = i5.busy;
      obs_done        = i5.done;
      obs_c[9:0]      = i5.c_out;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic check_c(input string tag, input int n, input logic [W-1:0] exp);
    for (int k = 0; k < (2*n + 63) / 64; k++)
      check($sformatf("%s[%0d]", tag, k), obs_c[64*k +: 64], exp[64*k +: 64]);
  endtask

  task automatic drive(input logic st, input logic [W-1:0] b, input logic v, input logic [1:0] coef);
    if (sel != 0) begin
      i701.start = st; i701.b_in = b[1401:0]; i701.m_valid = v; i701.m_coef = coef;
    end else begin
      i5.start = st; i5.b_in = b[9:0]; i5.m_valid = v; i5.m_coef = coef;
    end
  endtask

  function automatic int dec(input logic [1:0] v);
    return (v == 2'b01) ? 1 : (v == 2'b11) ? 2 : 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    return (v == 1) ? 2'b01 : (v == 2) ? 2'b11 : 2'b00;
  endfunction

  // Cyclic convolution mod 3, optionally followed by reduction mod Phi_N.
  function automatic logic [W-1:0] model(input int n, input logic [W-1:0] b, input logic [W-1:0] m);
    int c[701];
    int mj, top;
    logic [W-1:0] r;
    for (int k = 0; k < n; k++) c[k] = 0;
    for (int j = 0; j < n; j++) begin
      mj = dec(m[2*j +: 2]);
      if (mj != 0)
        for (int i = 0; i < n; i++) c[(i + j) % n] += mj * dec(b[2*i +: 2]);
    end
    for (int k = 0; k < n; k++) c[k] = c[k] % 3;
    top = c[n-1];
    r = '0;
    for (int k = 0; k < n; k++) begin
      if (RED != 0) c[k] = (c[k] - top + 3) % 3;
      r[2*k +: 2] = enc(c[k]);
    end
    return r;
  endfunction

  // One product on the selected instance; expected handshake is tracked from the bench's own beat count.
  task automatic run(input int s, input int n, input logic [W-1:0] b, input logic [W-1:0] m,
                     input bit gaps, input bit extra_start, input int abort_at,
                     input logic [W-1:0] c_exp, input string name, output int done_t);
    int j, done_exp;
    bit fin, v;
    j = 0; done_exp = -1; fin = 0; done_t = -1;
    sel = s;
    @(negedge clk);
    drive(1'b1, b, 1'b0, 2'b00);
    for (int t = 1; t <= 4*n + 20 && !fin; t++) begin
      @(negedge clk);
      if (obs_done && done_t < 0) done_t = t;
      check({name, "_m_ready"}, 64'(obs_m_ready), 64'(j < n));
      check({name, "_busy"},    64'(obs_busy),    64'd1);
      check({name, "_done"},    64'(obs_done),    64'(t == done_exp));
      if (t == done_exp) begin
        check_c({name, "_c_out"}, n, c_exp);
        fin = 1;
      end else if (abort_at >= 0 && j == abort_at) begin
        drive(1'b0, b, 1'b1, m[2*j +: 2]);
        if (s != 0) rst701 = 1'b1; else rst5 = 1'b1;
        @(negedge clk);
        if (s != 0) rst701 = 1'b0; else rst5 = 1'b0;
        drive(1'b0, b, 1'b0, 2'b00);
        check({name, "_rst_m_ready"}, 64'(obs_m_ready), 64'd0);
        check({name, "_rst_busy"},    64'(obs_busy),    64'd0);
        check({name, "_rst_done"},    64'(obs_done),    64'd0);
        check_c({name, "_rst_c_out"}, n, '0);
        return;
      end else if (j < n) begin
        v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
        drive(extra_start && t == 3, extra_start && t == 3 ? ~b : b, v,
              v ? m[2*j +: 2] : 2'($urandom_range(0, 3)));
        if (v) begin
          j++;
          if (j == n) done_exp = t + 1 + RED;
        end
      end else begin
        drive(1'b0, b, 1'b1, 2'b01);  // stray beat while m_ready is low must be ignored
      end
    end
    if (!fin) check({name, "_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    drive(1'b0, b, 1'b0, 2'b00);
    check({name, "_idle_busy"}, 64'(obs_busy), 64'd0);
    check({name, "_idle_done"}, 64'(obs_done), 64'd0);
    check_c({name, "_hold_c_out"}, n, c_exp);
  endtask

  logic [W-1:0] b, m, ce;
  int dt;

  initial begin
    i5.start = 0;   i5.b_in = '0;   i5.m_valid = 0;   i5.m_coef = 2'b00;
    i701.start = 0; i701.b_in = '0; i701.m_valid = 0; i701.m_coef = 2'b00;
    repeat (2) @(negedge clk);
    rst5 = 1'b0; rst701 = 1'b0;
    check("rst5_busy",    64'(i5.busy),    64'd0);
    check("rst5_m_ready", 64'(i5.m_ready), 64'd0);
    check("rst5_done",    64'(i5.done),    64'd0);
    check("rst5_c_out",   64'(i5.c_out),   64'd0);
    check("rst701_busy",  64'(i701.busy),  64'd0);
    check("rst701_c_lo",  i701.c_out[63:0], 64'd0);

    // b = 1, m = -x^3 -> c = -x^3
    b = '0; m = '0; ce = '0;
    b[9:0] = 10'b00_00_00_00_01; m[9:0] = 10'b00_11_00_00_00; ce[9:0] = 10'b00_11_00_00_00;
    run(0, 5, b, m, 0, 0, -1, ce, "t1", dt);
    check("t1_latency", 64'(dt), 64'(6 + RED));

    // b = 1 + x, m = 1 + x -> 1 + 2x + x^2 = 1 - x + x^2
    b[9:0] = 10'b00_00_00_01_01; m[9:0] = 10'b00_00_00_01_01; ce[9:0] = 10'b00_00_01_11_01;
    run(0, 5, b, m, 0, 0, -1, ce, "t2", dt);

    // b = x^4, m = x -> x^5 wraps to 1
    b[9:0] = 10'b01_00_00_00_00; m[9:0] = 10'b00_00_00_01_00; ce[9:0] = 10'b00_00_00_00_01;
    run(0, 5, b, m, 0, 0, -1, ce, "t3", dt);
    check("t3_latency", 64'(dt), 64'(6 + RED));

    // b = x^4, m = 1 -> x^4, or -(1 + x + x^2 + x^3) after Phi_5 reduction
    b[9:0] = 10'b01_00_00_00_00; m[9:0] = 10'b00_00_00_00_01;
    ce[9:0] = (RED != 0) ? 10'b00_11_11_11_11 : 10'b01_00_00_00_00;
    run(0, 5, b, m, 0, 0, -1, ce, "t4", dt);

    // rst and start together: reset wins
    sel = 0;
    @(negedge clk);
    i5.start = 1'b1; rst5 = 1'b1;
    @(negedge clk);
    i5.start = 1'b0; rst5 = 1'b0;
    check("rst_prio_busy",  64'(i5.busy),  64'd0);
    check("rst_prio_c_out", 64'(i5.c_out), 64'd0);

    // random operands (including the 10 code), gapped beats, stray start during RUN
    for (int k = 0; k < 3; k++) begin
      b = '0; m = '0;
      b[9:0] = 10'($urandom); m[9:0] = 10'($urandom);
      run(0, 5, b, m, 1, 1, -1, model(5, b, m), $sformatf("rnd%0d", k), dt);
    end

    // N=701: repeating 0,+1,-1 coefficient pattern as b, random m
    b = '0; m = '0;
    for (int i = 0; i < 701; i++) begin
      b[2*i +: 2] = (i % 3 == 0) ? 2'b00 : (i % 3 == 1) ? 2'b01 : 2'b11;
      m[2*i +: 2] = 2'($urandom_range(0, 3));
    end
    run(1, 701, b, m, 0, 0, 300, '0, "abort", dt);
    run(1, 701, b, m, 0, 0, -1, model(701, b, m), "full", dt);
    check("full_latency", 64'(dt), 64'(702 + RED));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
